usrt_tx_engine: RTL and testbench

Parametrised USRT transmit engine. It replaces the fixed 8-bit serializer and the free-running baud_gen pair with one block: a push FIFO, a programmable-length bit timer, and a framing state machine. The engine drives the serial data line and the companion synchronous bit clock towards the USRT Rx side. The APB-side enable logic pushes bytes into the FIFO.

---
 rtl/usrt_tx_engine.sv | 260 ++++++++++++++++++++++++++
 tb/tb_usrt_tx_engine.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usrt_tx_engine.sv
// USRT transmit engine: push FIFO, programmable bit timer and framing FSM driving tx/uclk_out.
// Optional build macro USRT_TX_STOP2_EN adds the stop2 input (two stop bits per frame).
module usrt_tx_engine #(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int BAUD_DIV    = 80,
    parameter int PARITY_MODE = 1
) (
    input  logic                        pClk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [DATA_W-1:0]           push_data,
`ifdef USRT_TX_STOP2_EN
    input  logic                        stop2,
`endif
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overflow,
    output logic                        tx,
    output logic                        uclk_out,
    output logic                        busy,
    output logic                        frame_done
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int TW   = $clog2(BAUD_DIV);
    localparam int BW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int HALF = BAUD_DIV / 2;

    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("usrt_tx_engine: PARITY_MODE must be 0, 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || BAUD_DIV < 2 ||
        DATA_W < 1 || DATA_W > 16) begin : g_bad_geometry
        $error("usrt_tx_engine: illegal FIFO_DEPTH, BAUD_DIV or DATA_W");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic calc_parity(input logic [DATA_W-1:0] d);
        calc_parity = (PARITY_MODE == 32'sd2) ? ~(^d) : (^d);
    endfunction

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d, overflow_q, overflow_d;
    logic              push_ok_s, pop_s, stop2_in_s, last_tick_s, stop_end_s;
    logic [DATA_W-1:0] head_s;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_q, par_d, stop2_q, stop2_d, stop_half_q, stop_half_d;
    logic              tx_q, tx_d, uclk_q, uclk_d, busy_q, busy_d, frame_done_q, frame_done_d;

`ifdef USRT_TX_STOP2_EN
    assign stop2_in_s = stop2;
`else
    assign stop2_in_s = 1'b0;
`endif

    assign head_s = mem_q[rd_ptr_q];

    // FIFO next state; acceptance uses the pre-edge count so a same-cycle pop never frees a slot
    always_comb begin
        mem_d     = mem_q;
        push_ok_s = push && (count_q != CW'(FIFO_DEPTH));
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
        full_d     = (count_d == CW'(FIFO_DEPTH));
        overflow_d = push && !push_ok_s;
    end

    // FIFO storage, pointers and status flags
    always_ff @(posedge pClk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // Framing FSM: bit timer, data shift, and frame loading from the FIFO head
    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        stop2_d     = stop2_q;
        stop_half_d = stop_half_q;
        pop_s       = 1'b0;
        stop_end_s  = 1'b0;
        last_tick_s = (timer_q == TW'(BAUD_DIV - 1));
        if (state_q == ST_IDLE || last_tick_s) begin
            timer_d = {TW{1'b0}};
        end else begin
            timer_d = timer_q + TW'(1'b1);
        end
        case (state_q)
            ST_IDLE: begin
                if (count_q != {CW{1'b0}}) begin
                    pop_s   = 1'b1;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (last_tick_s) begin
                    state_d = ST_DATA;
                    bit_d   = {BW{1'b0}};
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (last_tick_s) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BW'(DATA_W - 1)) begin
                        state_d     = (PARITY_MODE != 32'sd0) ? ST_PARITY : ST_STOP;
                        stop_half_d = 1'b0;
                    end else begin
                        bit_d = bit_q + BW'(1'b1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (last_tick_s) begin
                    state_d     = ST_STOP;
                    stop_half_d = 1'b0;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (last_tick_s && stop2_q && !stop_half_q) begin
                    stop_half_d = 1'b1;
                end else if (last_tick_s) begin
                    // Queue not empty: chain straight into the next start bit
                    stop_end_s = 1'b1;
                    if (count_q != {CW{1'b0}}) begin
                        pop_s   = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (pop_s) begin
            shreg_d     = head_s;
            par_d       = calc_parity(head_s);
            stop2_d     = stop2_in_s;
            stop_half_d = 1'b0;
        end else begin
            par_d       = par_q;
        end
    end

    // FSM state registers
    always_ff @(posedge pClk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= {TW{1'b0}};
            bit_q       <= {BW{1'b0}};
            shreg_q     <= {DATA_W{1'b0}};
            par_q       <= 1'b0;
            stop2_q     <= 1'b0;
            stop_half_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            stop2_q     <= stop2_d;
            stop_half_q <= stop_half_d;
        end
    end

    // Line outputs, one cycle behind the FSM so tx, uclk_out and frame_done stay aligned
    always_comb begin
        case (state_q)
            ST_IDLE:   tx_d = 1'b0;
            ST_START:  tx_d = 1'b1;
            ST_DATA:   tx_d = shreg_q[0];
            ST_PARITY: tx_d = par_q;
            ST_STOP:   tx_d = 1'b0;
            default:   tx_d = 1'b0;
        endcase
        busy_d       = (state_q != ST_IDLE);
        uclk_d       = busy_d && (timer_q < TW'(HALF));
        frame_done_d = stop_end_s;
    end

    // Output registers
    always_ff @(posedge pClk) begin
        if (rst) begin
            tx_q         <= 1'b0;
            uclk_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            tx_q         <= tx_d;
            uclk_q       <= uclk_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign full       = full_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign tx         = tx_q;
    assign uclk_out   = uclk_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_usrt_tx_engine.sv
// Directed bench for usrt_tx_engine: default instance plus odd-parity and no-parity instances.
`timescale 1ns/1ps
module tb_usrt_tx_engine;
    logic       pClk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0, push_o = 1'b0, push_n = 1'b0;
    logic [7:0] push_data = 8'h00;
`ifdef USRT_TX_STOP2_EN
    logic       stop2 = 1'b0;
`endif
    logic       full, overflow, tx, uclk, busy, fd;
    logic [2:0] count;
    logic       full_o, overflow_o, tx_o, uclk_o, busy_o, fd_o;
    logic [2:0] count_o;
    logic       full_n, overflow_n, tx_n, uclk_n, busy_n, fd_n;
    logic [2:0] count_n;
    int total = 0;
    int bad   = 0;

    always #5 pClk = ~pClk;

    usrt_tx_engine dut (
        .pClk(pClk), .rst(rst), .push(push), .push_data(push_data),
`ifdef USRT_TX_STOP2_EN
        .stop2(stop2),
`endif
        .full(full), .count(count), .overflow(overflow), .tx(tx),
        .uclk_out(uclk), .busy(busy), .frame_done(fd));

    usrt_tx_engine #(.BAUD_DIV(4), .PARITY_MODE(2)) dut_odd (
        .pClk(pClk), .rst(rst), .push(push_o), .push_data(push_data),
`ifdef USRT_TX_STOP2_EN
        .stop2(1'b0),
`endif
        .full(full_o), .count(count_o), .overflow(overflow_o), .tx(tx_o),
        .uclk_out(uclk_o), .busy(busy_o), .frame_done(fd_o));

    usrt_tx_engine #(.BAUD_DIV(4), .PARITY_MODE(0)) dut_np (
        .pClk(pClk), .rst(rst), .push(push_n), .push_data(push_data),
`ifdef USRT_TX_STOP2_EN
        .stop2(1'b0),
`endif
        .full(full_n), .count(count_n), .overflow(overflow_n), .tx(tx_n),
        .uclk_out(uclk_n), .busy(busy_n), .frame_done(fd_n));

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pClk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; push = 1'b0; push_o = 1'b0; push_n = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        total++; if (tx !== 1'b0)         begin bad++; $display("FAIL reset_tx: got %b want 0", tx); end
        total++; if (uclk !== 1'b0)       begin bad++; $display("FAIL reset_uclk: got %b want 0", uclk); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (fd !== 1'b0)         begin bad++; $display("FAIL reset_fd: got %b want 0", fd); end
        total++; if (count !== 3'd0)      begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (full !== 1'b0)       begin bad++; $display("FAIL reset_full: got %b want 0", full); end
        total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        total++; if ({tx_o, busy_o, tx_n, busy_n} !== 4'b0000)
            begin bad++; $display("FAIL reset_small: got %b want 0000", {tx_o, busy_o, tx_n, busy_n}); end
        rst = 1'b0;
    endtask

    task automatic test_frame();
        logic [10:0] exp_bits;
        exp_bits = {1'b0, 1'b0, 8'hA5, 1'b1};
        do_reset();
        push_data = 8'hA5; push = 1'b1;
        step(1);
        push = 1'b0;
        total++; if (count !== 3'd1) begin bad++; $display("FAIL frame_count_e0: got %0d want 1", count); end
        total++; if (tx !== 1'b0)    begin bad++; $display("FAIL frame_tx_e0: got %b want 0", tx); end
        step(1);
        total++; if (tx !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL frame_e1: tx=%b busy=%b want 0 0", tx, busy); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL frame_count_e1: got %0d want 0", count); end
        step(1);
        for (int b = 0; b < 11; b++) begin
            for (int k = 0; k < 80; k++) begin
                total++; if (tx !== exp_bits[b])
                    begin bad++; $display("FAIL frame_tx bit %0d cyc %0d: got %b want %b", b, k, tx, exp_bits[b]); end
                total++; if (uclk !== (k < 40))
                    begin bad++; $display("FAIL frame_uclk bit %0d cyc %0d: got %b want %b", b, k, uclk, (k < 40)); end
                total++; if (fd !== (b == 10 && k == 79))
                    begin bad++; $display("FAIL frame_done bit %0d cyc %0d: got %b want %b", b, k, fd, (b == 10 && k == 79)); end
                total++; if (busy !== 1'b1)
                    begin bad++; $display("FAIL frame_busy bit %0d cyc %0d: got %b want 1", b, k, busy); end
                if (!(b == 10 && k == 79)) step(1);
            end
        end
        step(1);
        total++; if ({tx, uclk, busy, fd} !== 4'b0000)
            begin bad++; $display("FAIL frame_idle: tx/uclk/busy/fd got %b want 0000", {tx, uclk, busy, fd}); end
    endtask

    task automatic test_back_to_back();
        int e;
        logic v0, v7, vp;
        do_reset();
        push_data = 8'h01; push = 1'b1; step(1);
        push_data = 8'h80; step(1);
        push = 1'b0;
        step(721);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL b2b_par0: got %b want 1", tx); end
        step(159);
        total++; if (fd !== 1'b1 || tx !== 1'b0) begin bad++; $display("FAIL b2b_fd0: fd=%b tx=%b want 1 0", fd, tx); end
        step(1);
        total++; if ({tx, busy, fd} !== 3'b110) begin bad++; $display("FAIL b2b_start1: tx/busy/fd got %b want 110", {tx, busy, fd}); end
        e = 882; v0 = 1'bx; v7 = 1'bx; vp = 1'bx;
        while (fd !== 1'b1 && e < 2000) begin
            step(1);
            e++;
            if (e == 962)  v0 = tx;
            if (e == 1522) v7 = tx;
            if (e == 1602) vp = tx;
        end
        total++; if (e != 1761) begin bad++; $display("FAIL b2b_fd1_edge: got %0d want 1761", e); end
        total++; if ({v0, v7, vp} !== 3'b011) begin bad++; $display("FAIL b2b_bits1: got %b want 011", {v0, v7, vp}); end
    endtask

    task automatic test_overflow();
        logic [7:0] bytes [6];
        logic [7:0] got [5];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_data = bytes[i]; push = 1'b1;
            step(1);
            if (i == 1) begin
                total++; if (count !== 3'd1) begin bad++; $display("FAIL ovf_count_e1: got %0d want 1", count); end
            end
            if (i == 4) begin
                total++; if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0)
                    begin bad++; $display("FAIL ovf_e4: count=%0d full=%b ovf=%b want 4 1 0", count, full, overflow); end
            end
            if (i == 5) begin
                total++; if (count !== 3'd4 || overflow !== 1'b1)
                    begin bad++; $display("FAIL ovf_e5: count=%0d ovf=%b want 4 1", count, overflow); end
            end
        end
        push = 1'b0;
        step(1);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_pulse_end: got %b want 0", overflow); end
        for (int e = 7; e <= 4442; e++) begin
            int rel, fr, off;
            step(1);
            rel = e - 2; fr = rel / 880; off = rel % 880;
            if (fr < 5 && off >= 80 && off < 720 && off % 80 == 40) got[fr][off / 80 - 1] = tx;
            if (e == 880) begin
                total++; if (count !== 3'd4) begin bad++; $display("FAIL ovf_count_e880: got %0d want 4", count); end
            end
            if (e == 881) begin
                total++; if (count !== 3'd3 || full !== 1'b0)
                    begin bad++; $display("FAIL ovf_e881: count=%0d full=%b want 3 0", count, full); end
            end
        end
        for (int k = 0; k < 5; k++) begin
            total++; if (got[k] !== bytes[k]) begin bad++; $display("FAIL ovf_order frame %0d: got %h want %h", k, got[k], bytes[k]); end
        end
        total++; if (tx !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ovf_dropped: tx=%b busy=%b want 0 0", tx, busy); end
    endtask

    task automatic test_parity();
        do_reset();
        push_data = 8'hFF; push_o = 1'b1; push_n = 1'b1;
        step(1);
        push_n = 1'b0; push_data = 8'h07;
        step(1);
        push_o = 1'b0;
        for (int e = 2; e <= 95; e++) begin
            step(1);
            case (e)
                2:  begin total++; if (tx_o !== 1'b1 || uclk_o !== 1'b1) begin bad++; $display("FAIL par_start: tx=%b uclk=%b want 1 1", tx_o, uclk_o); end end
                4:  begin total++; if (uclk_o !== 1'b0) begin bad++; $display("FAIL par_uclk_low: got %b want 0", uclk_o); end end
                37: begin total++; if (tx_n !== 1'b1) begin bad++; $display("FAIL np_bit7: got %b want 1", tx_n); end end
                38: begin
                    total++; if (tx_o !== 1'b1) begin bad++; $display("FAIL odd_par_ff: got %b want 1", tx_o); end
                    total++; if (tx_n !== 1'b0) begin bad++; $display("FAIL np_stop: got %b want 0", tx_n); end
                end
                40: begin total++; if (fd_n !== 1'b0) begin bad++; $display("FAIL np_fd_early: got %b want 0", fd_n); end end
                41: begin total++; if (fd_n !== 1'b1) begin bad++; $display("FAIL np_fd: got %b want 1", fd_n); end end
                42: begin total++; if (busy_n !== 1'b0 || tx_n !== 1'b0) begin bad++; $display("FAIL np_idle: busy=%b tx=%b want 0 0", busy_n, tx_n); end end
                45: begin total++; if (fd_o !== 1'b1) begin bad++; $display("FAIL odd_fd0: got %b want 1", fd_o); end end
                46: begin total++; if (tx_o !== 1'b1 || busy_o !== 1'b1) begin bad++; $display("FAIL odd_start1: tx=%b busy=%b want 1 1", tx_o, busy_o); end end
                62: begin total++; if (tx_o !== 1'b0) begin bad++; $display("FAIL odd_bit3: got %b want 0", tx_o); end end
                82: begin total++; if (tx_o !== 1'b0) begin bad++; $display("FAIL odd_par_07: got %b want 0", tx_o); end end
                89: begin total++; if (fd_o !== 1'b1) begin bad++; $display("FAIL odd_fd1: got %b want 1", fd_o); end end
                95: begin
                    total++; if ({busy_o, count_o, full_o, overflow_o, uclk_n, full_n, overflow_n, count_n} !== 11'd0)
                        begin bad++; $display("FAIL small_idle: got %b want 0", {busy_o, count_o, full_o, overflow_o, uclk_n, full_n, overflow_n, count_n}); end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset_mid();
        int act;
        do_reset();
        push = 1'b1;
        push_data = 8'h5A; step(1);
        push_data = 8'hC3; step(1);
        push_data = 8'h0F; step(1);
        push = 1'b0;
        step(397);
        total++; if (busy !== 1'b1 || count !== 3'd2) begin bad++; $display("FAIL rmid_pre: busy=%b count=%0d want 1 2", busy, count); end
        rst = 1'b1;
        step(1);
        total++; if ({tx, busy, fd, full} !== 4'b0000 || count !== 3'd0)
            begin bad++; $display("FAIL rmid_abort: tx/busy/fd/full=%b count=%0d want 0000 0", {tx, busy, fd, full}, count); end
        rst = 1'b0;
        act = 0;
        for (int i = 0; i < 2000; i++) begin
            step(1);
            if (tx !== 1'b0 || busy !== 1'b0 || fd !== 1'b0 || uclk !== 1'b0 || count !== 3'd0) act++;
        end
        total++; if (act != 0) begin bad++; $display("FAIL rmid_quiet: active cycles got %0d want 0", act); end
    endtask

`ifdef USRT_TX_STOP2_EN
    task automatic test_stop2();
        do_reset();
        stop2 = 1'b1; push_data = 8'h3C; push = 1'b1;
        step(1);
        push = 1'b0;
        step(1);
        stop2 = 1'b0;
        step(880);
        total++; if (tx !== 1'b0 || fd !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL stop2_mid: tx=%b fd=%b busy=%b want 0 0 1", tx, fd, busy); end
        step(80);
        total++; if (fd !== 1'b1) begin bad++; $display("FAIL stop2_fd: got %b want 1", fd); end
        step(1);
        total++; if (busy !== 1'b0 || fd !== 1'b0) begin bad++; $display("FAIL stop2_idle: busy=%b fd=%b want 0 0", busy, fd); end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_frame();
        test_back_to_back();
        test_overflow();
        test_parity();
        test_reset_mid();
`ifdef USRT_TX_STOP2_EN
        test_stop2();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
